morse_letter_fifo_producer: RTL and testbench

//  Parametrised next-generation Morse sequence producer. Replaces the divided-clock

---
 rtl/morse_letter_fifo_producer.sv | 192 +++++++++++++++++++
 tb/tb_morse_letter_fifo_producer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_letter_fifo_producer.sv
// Morse letter producer: tick-sampled button edges assemble dot/dash letters,
// which are queued with word gaps in a show-ahead valid/ready FIFO.
module morse_letter_fifo_producer #(
    parameter int MAX_SYMBOLS = 5,
    parameter int CLK_DIV     = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               Reset,
    input  logic                               Dot,
    input  logic                               Dash,
    input  logic                               Space,
    input  logic                               EndSeq,
    input  logic                               Clear,
    output logic [2*MAX_SYMBOLS-1:0]           out_bits,
    output logic [$clog2(MAX_SYMBOLS+1)-1:0]   out_len,
    output logic                               spa_end,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               sent,
    output logic                               sym_drop,
    output logic                               overflow
);
    localparam int BW = 2 * MAX_SYMBOLS;
    localparam int LW = $clog2(MAX_SYMBOLS + 1);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = BW + LW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUILD = 2'd1, S_FULL = 2'd2} state_e;

    logic [CW-1:0] div_q, div_d;
    logic          tick_s;
    logic [4:0]    lvl_s, prev_q, prev_d, ev_s;
    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [BW-1:0] bits_q, bits_d;
    logic          push_req_s, push_spa_s, add_s, drop_s, clr_s, push_ok_s, pop_s;
    logic [1:0]    code_s;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic          full_s, empty_s;
    logic [EW-1:0] head_s;
    logic          sent_q, drop_q, ovf_q, ovf_d;

    assign tick_s = (div_q == CW'(CLK_DIV - 1));
    assign lvl_s  = {Clear, EndSeq, Space, Dash, Dot};

    // Sample divider and rising-edge detection on tick.
    always_comb begin
        if (tick_s) begin
            div_d  = '0;
            prev_d = lvl_s;
            ev_s   = lvl_s & ~prev_q;
        end else begin
            div_d  = div_q + CW'(1);
            prev_d = prev_q;
            ev_s   = 5'b00000;
        end
    end

    assign empty_s   = (wr_q == rd_q);
    assign full_s    = ((wr_q - rd_q) == PW'(FIFO_DEPTH));
    assign pop_s     = ~empty_s & out_ready;
    assign push_ok_s = push_req_s & (~full_s | pop_s);

    // Assembly FSM: state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bits_q  <= bits_d;
        end
    end

    // Assembly FSM: output decode with Clear > EndSeq > Space > Dash > Dot priority.
    always_comb begin
        push_req_s = 1'b0;
        push_spa_s = 1'b0;
        add_s      = 1'b0;
        drop_s     = 1'b0;
        clr_s      = 1'b0;
        code_s     = 2'b00;
        if (ev_s[4]) begin
            clr_s = 1'b1;
        end else if (ev_s[3]) begin
            push_req_s = (state_q != S_IDLE);
        end else if (ev_s[2]) begin
            push_req_s = 1'b1;
            push_spa_s = 1'b1;
        end else if (ev_s[1] || ev_s[0]) begin
            code_s = ev_s[1] ? 2'b10 : 2'b01;
            if (state_q == S_FULL) begin
                drop_s = 1'b1;
            end else begin
                add_s = 1'b1;
            end
        end else begin
            code_s = 2'b00;
        end
    end

    // Assembly FSM: next state; a rejected push leaves the letter intact for retry.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bits_d  = bits_q;
        if (clr_s || push_ok_s) begin
            state_d = S_IDLE;
            len_d   = '0;
            bits_d  = '0;
        end else if (add_s) begin
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
                if (len_q == LW'(i)) begin
                    bits_d[2*i +: 2] = code_s;
                end else begin
                    bits_d[2*i +: 2] = bits_q[2*i +: 2];
                end
            end
            len_d   = len_q + LW'(1);
            state_d = (len_q == LW'(MAX_SYMBOLS - 1)) ? S_FULL : S_BUILD;
        end else begin
            state_d = state_q;
        end
    end

    // Overflow is sticky until Clear.
    always_comb begin
        if (clr_s) begin
            ovf_d = 1'b0;
        end else if (push_req_s && !push_ok_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Divider, edge history, FIFO pointers/storage and status pulses.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            div_q  <= '0;
            prev_q <= 5'b00000;
            wr_q   <= '0;
            rd_q   <= '0;
            sent_q <= 1'b0;
            drop_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            div_q  <= div_d;
            prev_q <= prev_d;
            sent_q <= push_ok_s;
            drop_q <= drop_s;
            ovf_q  <= ovf_d;
            if (push_ok_s) begin
                mem_q[wr_q[AW-1:0]] <= {push_spa_s, len_q, bits_q};
                wr_q                <= wr_q + PW'(1);
            end
            if (pop_s) begin
                rd_q <= rd_q + PW'(1);
            end
        end
    end

    assign head_s = mem_q[rd_q[AW-1:0]];

    // Show-ahead head, forced to zero while empty.
    always_comb begin
        if (empty_s) begin
            out_bits = '0;
            out_len  = '0;
            spa_end  = 1'b0;
        end else begin
            out_bits = head_s[BW-1:0];
            out_len  = head_s[BW +: LW];
            spa_end  = head_s[EW-1];
        end
    end

    assign out_valid = ~empty_s;
    assign sent      = sent_q;
    assign sym_drop  = drop_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_morse_letter_fifo_producer.sv
// Randomized and directed bench for morse_letter_fifo_producer with a queue-based
// reference model and a handshake-driven scoreboard monitor.
module tb_morse_letter_fifo_producer;
    localparam int MAXS  = 5;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       spa;
        logic [2:0] len;
        logic [9:0] bits;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] vec = 5'b00000;   // {Clear, EndSeq, Space, Dash, Dot}
    logic       rdy = 1'b0;
    logic [9:0] out_bits;
    logic [2:0] out_len;
    logic       spa_end, out_valid, sent, sym_drop, overflow;

    int   n_pass = 0;
    int   n_total = 0;
    ent_t sb[$];
    ent_t mf[$];
    int   m_syms[$];
    int   m_e;
    logic [4:0] m_prev;
    logic m_ovf, exp_sent, exp_drop;
    logic last_sent, last_drop;

    morse_letter_fifo_producer #(.MAX_SYMBOLS(MAXS), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .Reset(rst_n),
        .Dot(vec[0]), .Dash(vec[1]), .Space(vec[2]), .EndSeq(vec[3]), .Clear(vec[4]),
        .out_bits(out_bits), .out_len(out_len), .spa_end(spa_end), .out_valid(out_valid),
        .out_ready(rdy), .sent(sent), .sym_drop(sym_drop), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        sb.delete(); mf.delete(); m_syms.delete();
        m_prev = 5'b00000; m_ovf = 1'b0; m_e = 0;
        exp_sent = 1'b0; exp_drop = 1'b0;
    endfunction

    // One clock edge of the reference model, evaluated before the edge happens.
    function automatic void model_step();
        bit   tick, pop, do_push;
        ent_t ne;
        logic [4:0] ev;
        tick = ((m_e % DIV) == DIV - 1);
        m_e++;
        pop = rdy && (mf.size() > 0);
        exp_sent = 1'b0; exp_drop = 1'b0; do_push = 0; ne = '0;
        if (tick) begin
            ev = vec & ~m_prev;
            m_prev = vec;
            if (ev[4]) begin
                m_syms.delete();
                m_ovf = 1'b0;
            end else if (ev[3] || ev[2]) begin
                if (!(ev[3] && m_syms.size() == 0)) begin
                    for (int i = 0; i < m_syms.size(); i++)
                        ne.bits = ne.bits | (10'(m_syms[i]) << (2 * i));
                    ne.len = 3'(m_syms.size());
                    ne.spa = !ev[3];
                    if (mf.size() < DEPTH || pop) begin
                        do_push = 1;
                        m_syms.delete();
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end else if (ev[1] || ev[0]) begin
                if (m_syms.size() == MAXS) exp_drop = 1'b1;
                else m_syms.push_back(ev[1] ? 2 : 1);
            end
        end
        if (pop) void'(mf.pop_front());
        if (do_push) begin
            mf.push_back(ne);
            sb.push_back(ne);
            exp_sent = 1'b1;
        end
    endfunction

    // Scoreboard monitor: every accepted handshake must match the oldest expected entry.
    always @(negedge clk) begin
        ent_t e;
        if (rst_n && out_valid && rdy) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL pop_unexpected: got bits %0h with no expected entry", out_bits);
            end else begin
                e = sb.pop_front();
                chk("pop_bits", out_bits, e.bits);
                chk("pop_len", out_len, e.len);
                chk("pop_spa", spa_end, e.spa);
            end
        end
    end

    task automatic cycle();
        model_step();
        @(posedge clk); #2;
        chk("sent", sent, exp_sent);
        chk("sym_drop", sym_drop, exp_drop);
        chk("overflow", overflow, m_ovf);
        chk("out_valid", out_valid, mf.size() > 0);
        if (mf.size() > 0) begin
            chk("head_bits", out_bits, mf[0].bits);
            chk("head_len", out_len, mf[0].len);
            chk("head_spa", spa_end, mf[0].spa);
        end else begin
            chk("empty_zero", {spa_end, out_len, out_bits}, 0);
        end
    endtask

    task automatic wait_tick();
        while ((m_e % DIV) != DIV - 1) cycle();
    endtask

    task automatic press(input logic [4:0] v);
        vec = 5'b00000;
        wait_tick();
        vec = v;
        cycle();
        last_sent = sent;
        last_drop = sym_drop;
        vec = 5'b00000;
        wait_tick();
        cycle();
    endtask

    task automatic drain();
        rdy = 1'b1;
        for (int i = 0; i < 3 * DEPTH && mf.size() > 0; i++) cycle();
        rdy = 1'b0;
    endtask

    initial begin
        logic [4:0] rv;
        int r, hold;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_head", {spa_end, out_len, out_bits}, 0);
        chk("reset_status", {sent, sym_drop, overflow}, 0);
        #1 rst_n = 1'b1;

        // Reset mid-letter discards FIFO and assembly.
        press(5'b00001); press(5'b01000);
        press(5'b00001); press(5'b00001); press(5'b00001);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", out_valid, 0);
        chk("midreset_head", {spa_end, out_len, out_bits}, 0);
        chk("midreset_status", {sent, sym_drop, overflow}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        press(5'b00010); press(5'b01000);
        chk("after_reset_bits", out_bits, 10'h002);
        chk("after_reset_len", out_len, 1);
        drain();

        // Dot, Dash, Dot, EndSeq.
        press(5'b00001); press(5'b00010); press(5'b00001); press(5'b01000);
        chk("ddd_bits", out_bits, 10'h019);
        chk("ddd_len", out_len, 3);
        chk("ddd_spa", spa_end, 0);
        drain();

        // Six dashes then Space: sixth is dropped.
        for (int i = 0; i < 6; i++) press(5'b00010);
        chk("sixth_drop", last_drop, 1);
        press(5'b00100);
        chk("full_bits", out_bits, 10'h2AA);
        chk("full_len", out_len, 5);
        chk("full_spa", spa_end, 1);
        drain();

        // Pure word gap, then EndSeq on empty letter.
        press(5'b00100);
        chk("gap_head", {spa_end, out_len, out_bits}, 14'h2000);
        drain();
        press(5'b01000);
        chk("empty_endseq_sent", last_sent, 0);
        chk("empty_endseq_valid", out_valid, 0);

        // Overflow on fifth letter, retry after one pop, Clear resets the flag.
        for (int i = 0; i < 5; i++) begin
            press(5'b00001); press(5'b01000);
        end
        chk("fifth_rejected", last_sent, 0);
        chk("overflow_set", overflow, 1);
        rdy = 1'b1; cycle(); rdy = 1'b0;
        press(5'b01000);
        chk("retry_sent", last_sent, 1);
        press(5'b10000);
        chk("overflow_cleared", overflow, 0);

        // Push and pop in the same cycle on a full FIFO.
        press(5'b00001);
        wait_tick();
        vec = 5'b01000; rdy = 1'b1;
        cycle();
        chk("full_pushpop_sent", sent, 1);
        chk("full_pushpop_ovf", overflow, 0);
        vec = 5'b00000; rdy = 1'b0;
        wait_tick(); cycle();
        drain();

        // Held Dot gives one symbol; Dot+Dash gives Dash only.
        wait_tick();
        vec = 5'b00001;
        repeat (5 * DIV) cycle();
        vec = 5'b00000;
        wait_tick(); cycle();
        press(5'b01000);
        chk("held_dot_len", out_len, 1);
        chk("held_dot_bits", out_bits, 10'h001);
        drain();
        press(5'b00011); press(5'b01000);
        chk("dotdash_bits", out_bits, 10'h002);
        drain();

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 35) rv = 5'b00000;
            else if (r < 50) rv = 5'b00001;
            else if (r < 65) rv = 5'b00010;
            else if (r < 75) rv = 5'b01000;
            else if (r < 82) rv = 5'b00100;
            else if (r < 85) rv = 5'b10000;
            else rv = 5'($urandom_range(0, 31));
            vec = rv;
            hold = $urandom_range(1, 2 * DIV);
            for (int j = 0; j < hold; j++) begin
                rdy = ($urandom_range(0, 9) < 6);
                cycle();
            end
        end
        vec = 5'b00000;
        drain();
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
